load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Consumes the ALU result as an effective address, plus rdata2 as store data.
- Performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) against the word-only data-memory/cache port, which uses a mem_read/mem_write/mem_ready handshake.
- Stalls the pipeline while an access is in flight.
- Aligns and extends load data; implements sub-word stores as read-modify-write.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_BITS, 32, width of effective address from the ALU.
- DATA_BITS, 32, register/memory word width; only 32 supported.
- MEM_ADDR_BITS, 30, word-address width on the memory port (ADDR_BITS-2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory instruction present this cycle; held stable while stall=1.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_BITS  effective address (ALU result).
- wdata  in  DATA_BITS  store data (rdata2).
- stall  out  1  pipeline must hold.
- resp_valid  out  1  access completed this cycle.
- load_data  out  DATA_BITS  aligned, extended load result.
- exc  out  1  misaligned/illegal access.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_addr  out  MEM_ADDR_BITS  word address = addr[31:2].
- mem_wdata  out  DATA_BITS  full word to write.
- mem_rdata  in  DATA_BITS  read word, valid when mem_ready=1.
- mem_ready  in  1  memory completes the current request this cycle.

Behaviour:
- Reset (async, immediate) sets state=IDLE. stall, resp_valid, exc, mem_read and mem_write = 0. load_data, mem_addr and mem_wdata = 0.
- States:
  - IDLE
  - RD: read for load.
  - WR: SW write.
  - RMW_RD: read phase of sub-word store.
  - RMW_WR: write phase of sub-word store.
  - DONE
- Legality is checked combinationally in IDLE:
  - Illegal funct3: load 011/110/111; store anything but 000/001/010.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- Illegal request in IDLE with req_valid=1: exc=1 for that cycle, stall=0, no memory access, state stays IDLE.
- Legal request in IDLE with req_valid=1 (accept cycle):
  - Latch we, funct3, addr, wdata; stall=1.
  - Next state: RD for a load, WR for SW, RMW_RD for SB/SH.
- RD / RMW_RD / WR / RMW_WR:
  - mem_read (RD, RMW_RD) or mem_write (WR, RMW_WR) held at 1, with mem_addr/mem_wdata stable, until the cycle mem_ready=1 is sampled.
  - stall=1 throughout.
  - Never assert mem_read and mem_write together.
- RD with mem_ready=1: register load_data, then go to DONE.
- RMW_RD with mem_ready=1: register the merged word, then go to RMW_WR.
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
- WR / RMW_WR with mem_ready=1: go to DONE.
- DONE: resp_valid=1, stall=0, next state IDLE.
  - A new req_valid seen in DONE is ignored; it is re-evaluated in IDLE next cycle.
- Load extraction: lane = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- load_data holds its value until the next load completes. It is unchanged by stores and exc.
- Latency with zero memory wait:
  - Load/SW: 3 cycles (accept, RD/WR, DONE); stall high for 2.
  - SB/SH: 4 cycles (accept, RMW_RD, RMW_WR, DONE); stall high for 3.
  - Each memory wait cycle adds 1.
- mem_ready outside RD/RMW_RD/WR/RMW_WR is ignored.
- Reset asserted mid-access aborts immediately: mem_read/mem_write drop asynchronously and no partial RMW write is issued afterwards.
- Address wrap: addr=0xFFFFFFFC maps to mem_addr=0x3FFFFFFF; no carry handling needed.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, mem_ready after 2 wait cycles -> mem_read=1 with mem_addr=0x40 for 3 cycles; resp_valid=1 next cycle; load_data=0xDEADBEEF; stall high 4 cycles total.
- LB addr=0x103 / LBU addr=0x103, mem_rdata=0x80FF1234, mem_ready immediate -> load_data=0xFFFFFF80 / 0x00000080. LH addr=0x102 -> 0xFFFF80FF.
- SB addr=0x201, wdata=0x000000AB, old word 0x11223344 -> RMW_RD at mem_addr=0x80, then mem_write with mem_wdata=0x1122AB44; resp_valid after 4 cycles with zero wait.
- SH addr=0x203 / LW addr=0x102 / funct3=011 load -> exc=1 for one cycle, stall=0, mem_read=mem_write=0 throughout, load_data unchanged.
- SW addr=0x10, wdata=0xCAFEF00D -> single write, no read cycle, mem_wdata=0xCAFEF00D.
- Reset during SB in RMW_RD -> mem_read drops the same cycle, no mem_write follows. After reset release, an LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: drives a word-only memory port with a ready handshake,
// aligns/extends loads and performs sub-word stores as read-modify-write.
module load_store_unit #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int MEM_ADDR_BITS = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_BITS-1:0]     addr,
  input  logic [DATA_BITS-1:0]     wdata,
  output logic                     stall,
  output logic                     resp_valid,
  output logic [DATA_BITS-1:0]     load_data,
  output logic                     exc,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0]     mem_wdata,
  input  logic [DATA_BITS-1:0]     mem_rdata,
  input  logic                     mem_ready
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]           state, state_nxt;
  logic [2:0]           funct3_p0;
  logic [ADDR_BITS-1:0] addr_p0;
  logic [DATA_BITS-1:0] wdata_p0;
  logic [DATA_BITS-1:0] load_data_p1;
  logic                 illegal, accept, in_access;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3, bad_align;
    if (we) bad_f3 = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else    bad_f3 = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    bad_align = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_f3 || bad_align;
  endfunction

  function automatic logic [DATA_BITS-1:0] extract_load(input logic [2:0] f3, input logic [1:0] lane,
                                                        input logic [DATA_BITS-1:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DATA_BITS-1:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [DATA_BITS-1:0] merge_store(input logic [2:0] f3, input logic [1:0] lane,
                                                       input logic [DATA_BITS-1:0] old_word,
                                                       input logic [15:0] wd);
    logic [DATA_BITS-1:0] res;
    res = old_word;
    if (f3[0]) res[{lane[1], 4'b0000} +: 16] = wd;
    else       res[{lane, 3'b000} +: 8] = wd[7:0];
    return res;
  endfunction

  assign illegal   = is_illegal(req_we, req_funct3, addr[1:0]);
  assign accept    = (state == IDLE) && req_valid && !illegal;
  assign in_access = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);

  assign exc        = (state == IDLE) && req_valid && illegal;
  assign stall      = accept || in_access;
  assign resp_valid = (state == DONE);
  assign mem_read   = (state == RD) || (state == RMW_RD);
  assign mem_write  = (state == WR) || (state == RMW_WR);
  assign mem_addr   = addr_p0[MEM_ADDR_BITS+1:2];
  assign mem_wdata  = wdata_p0;
  assign load_data  = load_data_p1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (!req_we)                  state_nxt = RD;
        else if (req_funct3 == 3'b010) state_nxt = WR;
        else                          state_nxt = RMW_RD;
      end
      RD, WR, RMW_WR: if (mem_ready) state_nxt = DONE;
      RMW_RD:         if (mem_ready) state_nxt = RMW_WR;
      default:        state_nxt = IDLE;
    endcase
  end

  // p0: request capture; p1: memory response (load result / merged store word)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      funct3_p0    <= 3'd0;
      addr_p0      <= '0;
      wdata_p0     <= '0;
      load_data_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        funct3_p0 <= req_funct3;
        addr_p0   <= addr;
        wdata_p0  <= wdata;
      end
      if (state == RD && mem_ready)
        load_data_p1 <= extract_load(funct3_p0, addr_p0[1:0], mem_rdata);
      if (state == RMW_RD && mem_ready)
        wdata_p0 <= merge_store(funct3_p0, addr_p0[1:0], mem_rdata, wdata_p0[15:0]);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: loads, stores, RMW, exceptions, reset abort.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] addr, wdata;
  logic        stall, resp_valid, exc, mem_read, mem_write, mem_ready;
  logic [31:0] load_data, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;

  int checks = 0;
  int errors = 0;

  // results of the most recent run_op
  int          r_stall, r_rd, r_wr, r_resp, r_exc;
  logic [29:0] r_rd_addr, r_wr_addr;
  logic [31:0] r_wdata;
  logic        r_both, r_timeout;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .resp_valid(resp_valid), .load_data(load_data),
    .exc(exc), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Drives one request and acts as a memory with 'waits' wait cycles per phase.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int  wcnt;
    bit  done;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; addr = a; wdata = wd;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    r_stall = 0; r_rd = 0; r_wr = 0; r_resp = -1; r_exc = 0;
    r_rd_addr = '0; r_wr_addr = '0; r_wdata = '0; r_both = 1'b0; r_timeout = 1'b0;
    wcnt = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (resp_valid) begin done = 1'b1; r_resp = c; end
      if (stall) r_stall++;
      if (exc) r_exc++;
      if (mem_read)  begin r_rd++; r_rd_addr = mem_addr; end
      if (mem_write) begin r_wr++; r_wr_addr = mem_addr; r_wdata = mem_wdata; end
      if (mem_read && mem_write) r_both = 1'b1;
      if ((mem_read || mem_write) && wcnt >= waits) begin
        mem_ready = 1'b1; mem_rdata = rd; wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        if (mem_read || mem_write) wcnt++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; mem_ready = 1'b0;
    if (!done) r_timeout = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; addr = 32'h0;
    wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({stall, resp_valid, exc, mem_read, mem_write} !== 5'b0 || load_data !== 32'h0 ||
        mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: ctrl=%b load_data=%h mem_addr=%h mem_wdata=%h required all zero",
               {stall, resp_valid, exc, mem_read, mem_write}, load_data, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw_wait;
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    checks++;
    if (r_timeout || r_rd !== 3 || r_rd_addr !== 30'h40 || r_resp !== 4 || r_stall !== 4 || r_wr !== 0) begin
      errors++;
      $display("FAIL lw_wait: rd=%0d addr=%h resp=%0d stall=%0d wr=%0d required 3 40 4 4 0",
               r_rd, r_rd_addr, r_resp, r_stall, r_wr);
    end
    checks++;
    if (load_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_wait_data: got %h required DEADBEEF", load_data);
    end
  endtask

  task automatic test_subword_loads;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f3s[i], as[i], 32'h0, 32'h80FF1234, 0);
      checks++;
      if (r_timeout || load_data !== exp[i] || r_resp !== 2 || r_stall !== 2) begin
        errors++;
        $display("FAIL load_%0d: data=%h resp=%0d stall=%0d required %h 2 2",
                 i, load_data, r_resp, r_stall, exp[i]);
      end
    end
  endtask

  task automatic test_sub_stores;
    logic [31:0] prev;
    prev = load_data;
    run_op(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h11223344, 0);
    checks++;
    if (r_timeout || r_rd !== 1 || r_rd_addr !== 30'h80 || r_wr !== 1 || r_wr_addr !== 30'h80 ||
        r_wdata !== 32'h1122AB44 || r_resp !== 3 || r_stall !== 3 || r_both) begin
      errors++;
      $display("FAIL sb: rd=%0d ra=%h wr=%0d wa=%h wdata=%h resp=%0d stall=%0d both=%b required 1 80 1 80 1122AB44 3 3 0",
               r_rd, r_rd_addr, r_wr, r_wr_addr, r_wdata, r_resp, r_stall, r_both);
    end
    run_op(1'b1, 3'b001, 32'h202, 32'hFFFF5566, 32'h11223344, 1);
    checks++;
    if (r_timeout || r_wdata !== 32'h55663344 || r_rd !== 2 || r_wr !== 2 || r_resp !== 5 || r_both) begin
      errors++;
      $display("FAIL sh: wdata=%h rd=%0d wr=%0d resp=%0d both=%b required 55663344 2 2 5 0",
               r_wdata, r_rd, r_wr, r_resp, r_both);
    end
    checks++;
    if (load_data !== prev) begin
      errors++;
      $display("FAIL store_keeps_load_data: got %h required %h", load_data, prev);
    end
  endtask

  task automatic test_sw;
    run_op(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 0);
    checks++;
    if (r_timeout || r_rd !== 0 || r_wr !== 1 || r_wr_addr !== 30'h4 || r_wdata !== 32'hCAFEF00D ||
        r_resp !== 2 || r_stall !== 2) begin
      errors++;
      $display("FAIL sw: rd=%0d wr=%0d addr=%h wdata=%h resp=%0d stall=%0d required 0 1 4 CAFEF00D 2 2",
               r_rd, r_wr, r_wr_addr, r_wdata, r_resp, r_stall);
    end
  endtask

  task automatic test_exceptions;
    logic        wes [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] as  [4] = '{32'h203, 32'h102, 32'h100, 32'h100};
    logic [31:0] prev;
    for (int i = 0; i < 4; i++) begin
      prev = load_data;
      @(negedge clk);
      req_valid = 1'b1; req_we = wes[i]; req_funct3 = f3s[i]; addr = as[i]; wdata = 32'h12345678;
      #1;
      checks++;
      if (exc !== 1'b1 || stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL exc_%0d: exc=%b stall=%b rd=%b wr=%b required 1 0 0 0",
                 i, exc, stall, mem_read, mem_write);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if (exc !== 1'b0 || stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
          resp_valid !== 1'b0 || load_data !== prev) begin
        errors++;
        $display("FAIL exc_after_%0d: exc=%b stall=%b rd=%b wr=%b resp=%b data=%h required 0 0 0 0 0 %h",
                 i, exc, stall, mem_read, mem_write, resp_valid, load_data, prev);
      end
    end
  endtask

  task automatic test_addr_wrap;
    run_op(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0BADF00D, 0);
    checks++;
    if (r_timeout || r_rd_addr !== 30'h3FFFFFFF || load_data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL addr_wrap: addr=%h data=%h required 3FFFFFFF 0BADF00D", r_rd_addr, load_data);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int wr_seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; addr = 32'h301; wdata = 32'hEE;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL rmw_rd_before_reset: mem_read=%b required 1", mem_read);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: rd=%b wr=%b stall=%b required 0 0 0", mem_read, mem_write, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h11223344;
    wr_seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (mem_write || mem_read) wr_seen++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    checks++;
    if (wr_seen !== 0) begin
      errors++;
      $display("FAIL no_access_after_reset: got %0d access cycles required 0", wr_seen);
    end
    run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h76543210, 0);
    checks++;
    if (r_timeout || load_data !== 32'h76543210 || r_rd_addr !== 30'h100 || r_resp !== 2) begin
      errors++;
      $display("FAIL lw_after_reset: data=%h addr=%h resp=%0d required 76543210 100 2",
               load_data, r_rd_addr, r_resp);
    end
  endtask

  initial begin
    test_reset;
    test_lw_wait;
    test_subword_loads;
    test_sub_stores;
    test_sw;
    test_exceptions;
    test_addr_wrap;
    test_reset_mid_rmw;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
